sigmoid_inverse: RTL and testbench



---
 rtl/sigmoid_inverse_pkg.sv | 39 +++
 rtl/FloatingAddition.sv | 87 ++++++++
 rtl/FloatingDivision.sv | 60 ++++++
 rtl/sigmoid_inverse_addstep.sv | 42 ++++
 rtl/sigmoid_inverse.sv | 106 ++++++++++
 tb/tb_sigmoid_inverse.sv | 212 +++++++++++++++++++++
 6 files changed

// File: rtl/sigmoid_inverse_pkg.sv
// Shared constants, state encodings and input classification for the
// fast-sigmoid inverse and the other activation-layer blocks.
package sigmoid_inverse_pkg;

    localparam logic [31:0] FP_ONE     = 32'h3F80_0000;
    localparam logic [31:0] FP_NEG_ONE = 32'hBF80_0000;
    localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;
    localparam logic [31:0] FP_NEG_INF = 32'hFF80_0000;
    localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DBL  = 3'd1,
        SUB  = 3'd2,
        DEN  = 3'd3,
        DIV  = 3'd4,
        OUT  = 3'd5
    } stateT;

    typedef enum logic [1:0] {
        SPEC_NONE,
        SPEC_NAN,
        SPEC_POS_INF,
        SPEC_NEG_INF
    } specialT;

    // Activations outside the open interval (0,1) have no finite preimage.
    function automatic specialT classifyInput(input logic [31:0] y);
        if ((&y[30:23]) && (|y[22:0]))
            classifyInput = SPEC_NAN;
        else if (!y[31] && (y[30:0] >= FP_ONE[30:0]))
            classifyInput = SPEC_POS_INF;
        else if (y[31] || (y[30:0] == 31'd0))
            classifyInput = SPEC_NEG_INF;
        else
            classifyInput = SPEC_NONE;
    endfunction

endpackage

// File: rtl/FloatingAddition.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even,
// with full subnormal support on inputs and outputs.
module FloatingAddition (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_result
);

    logic        w_aNan, w_bNan, w_aInf, w_bInf;
    logic [31:0] w_big, w_small;
    logic [7:0]  w_expBig, w_expSmall, w_expDiff, w_shift;
    logic [23:0] w_mantBig, w_mantSmall;
    logic [50:0] w_alignWide;
    logic [26:0] w_mantAligned, w_norm;
    logic [27:0] w_sum;
    logic [4:0]  w_lz;
    logic [9:0]  w_expNorm;
    logic        w_roundUp;
    logic [24:0] w_rounded;
    logic [32:0] w_enc;

    function automatic logic [4:0] leadingZeros(input logic [26:0] v);
        leadingZeros = 5'd27;
        for (int i = 0; i <= 26; i++)
            if (v[i]) leadingZeros = 5'(26 - i);
    endfunction

    // Align the smaller magnitude with three extra bits (guard, round, sticky),
    // add or subtract, renormalise without dropping below the subnormal exponent.
    always_comb begin
        w_aNan = (&i_a[30:23]) && (|i_a[22:0]);
        w_bNan = (&i_b[30:23]) && (|i_b[22:0]);
        w_aInf = (&i_a[30:23]) && !(|i_a[22:0]);
        w_bInf = (&i_b[30:23]) && !(|i_b[22:0]);

        w_big   = (i_b[30:0] > i_a[30:0]) ? i_b : i_a;
        w_small = (i_b[30:0] > i_a[30:0]) ? i_a : i_b;

        w_expBig    = (w_big[30:23] == 8'd0) ? 8'd1 : w_big[30:23];
        w_expSmall  = (w_small[30:23] == 8'd0) ? 8'd1 : w_small[30:23];
        w_mantBig   = {(w_big[30:23] != 8'd0), w_big[22:0]};
        w_mantSmall = {(w_small[30:23] != 8'd0), w_small[22:0]};
        w_expDiff   = w_expBig - w_expSmall;

        w_alignWide   = {w_mantSmall, 27'd0} >> ((w_expDiff > 8'd50) ? 8'd50 : w_expDiff);
        w_mantAligned = {w_alignWide[50:25], w_alignWide[24] | (|w_alignWide[23:0])};

        if (w_big[31] == w_small[31])
            w_sum = {1'b0, w_mantBig, 3'd0} + {1'b0, w_mantAligned};
        else
            w_sum = {1'b0, w_mantBig, 3'd0} - {1'b0, w_mantAligned};

        w_lz      = leadingZeros(w_sum[26:0]);
        w_shift   = 8'd0;
        w_expNorm = {2'd0, w_expBig};
        w_norm    = w_sum[26:0];
        if (w_sum[27]) begin
            w_expNorm = {2'd0, w_expBig} + 10'd1;
            w_norm    = {w_sum[27:2], w_sum[1] | w_sum[0]};
        end else begin
            if ({3'd0, w_lz} < (w_expBig - 8'd1))
                w_shift = {3'd0, w_lz};
            else
                w_shift = w_expBig - 8'd1;
            w_expNorm = {2'd0, w_expBig - w_shift};
            w_norm    = w_sum[26:0] << w_shift;
        end

        w_roundUp = w_norm[2] & (w_norm[3] | w_norm[1] | w_norm[0]);
        w_rounded = {1'b0, w_norm[26:3]} + {24'd0, w_roundUp};
        w_enc     = ({23'd0, w_expNorm - 10'd1} << 23) + {8'd0, w_rounded};

        if (w_aNan || w_bNan || (w_aInf && w_bInf && (i_a[31] != i_b[31])))
            o_result = 32'h7FC0_0000;
        else if (w_aInf)
            o_result = i_a;
        else if (w_bInf)
            o_result = i_b;
        else if (w_sum == 28'd0)
            o_result = {i_a[31] & i_b[31], 31'd0};
        else if (w_enc >= 33'h0_7F80_0000)
            o_result = {w_big[31], 8'hFF, 23'd0};
        else
            o_result = {w_big[31], w_enc[30:0]};
    end

endmodule

// File: rtl/FloatingDivision.sv
// Combinational IEEE-754 single-precision divider, round-to-nearest-even.
// Subnormal operands and results are flushed to signed zero.
module FloatingDivision (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_result
);

    logic               w_sign, w_aZero, w_bZero, w_aMax, w_bMax;
    logic               w_aNan, w_bNan, w_preShift, w_roundUp;
    logic [23:0]        w_mantA, w_mantB;
    logic [24:0]        w_rem, w_rounded;
    logic [25:0]        w_quot;
    logic [22:0]        w_frac;
    logic signed [10:0] w_exp;

    // Restoring long division: 26 quotient bits give mantissa, guard and round.
    always_comb begin
        w_sign  = i_a[31] ^ i_b[31];
        w_aZero = (i_a[30:23] == 8'd0);
        w_bZero = (i_b[30:23] == 8'd0);
        w_aMax  = &i_a[30:23];
        w_bMax  = &i_b[30:23];
        w_aNan  = w_aMax && (|i_a[22:0]);
        w_bNan  = w_bMax && (|i_b[22:0]);
        w_mantA = {1'b1, i_a[22:0]};
        w_mantB = {1'b1, i_b[22:0]};

        w_preShift = (w_mantA < w_mantB);
        w_rem      = w_preShift ? {w_mantA, 1'b0} : {1'b0, w_mantA};
        w_quot     = 26'd0;
        for (int i = 25; i >= 0; i--) begin
            if (w_rem >= {1'b0, w_mantB}) begin
                w_quot[i] = 1'b1;
                w_rem     = w_rem - {1'b0, w_mantB};
            end
            w_rem = w_rem << 1;
        end

        w_roundUp = w_quot[1] & (w_quot[0] | (|w_rem) | w_quot[2]);
        w_rounded = {1'b0, w_quot[25:2]} + {24'd0, w_roundUp};
        w_frac    = w_rounded[24] ? w_rounded[23:1] : w_rounded[22:0];
        w_exp     = $signed({3'd0, i_a[30:23]}) - $signed({3'd0, i_b[30:23]}) + 11'sd127
                  - $signed({10'd0, w_preShift}) + $signed({10'd0, w_rounded[24]});

        if (w_aNan || w_bNan || (w_aMax && w_bMax) || (w_aZero && w_bZero))
            o_result = 32'h7FC0_0000;
        else if (w_aMax || w_bZero)
            o_result = {w_sign, 8'hFF, 23'd0};
        else if (w_aZero || w_bMax)
            o_result = {w_sign, 31'd0};
        else if (w_exp >= 11'sd255)
            o_result = {w_sign, 8'hFF, 23'd0};
        else if (w_exp <= 11'sd0)
            o_result = {w_sign, 31'd0};
        else
            o_result = {w_sign, w_exp[7:0], w_frac};
    end

endmodule

// File: rtl/sigmoid_inverse_addstep.sv
// The single shared adder with its operand selection for the DBL, SUB and
// DEN steps of the inverse-sigmoid sequence.
module sigmoid_inverse_addstep
    import sigmoid_inverse_pkg::*;
(
    input  stateT       i_state,
    input  logic [31:0] i_y,
    input  logic [31:0] i_t,
    input  logic [30:0] i_sMag,
    output logic [31:0] o_sum
);

    logic [31:0] w_opA;
    logic [31:0] w_opB;

    // Forcing the sign bit of s gives 1 - |s| without a separate abs step.
    always_comb begin
        w_opA = i_y;
        w_opB = i_y;
        case (i_state)
            SUB: begin
                w_opA = i_t;
                w_opB = FP_NEG_ONE;
            end
            DEN: begin
                w_opA = FP_ONE;
                w_opB = {1'b1, i_sMag};
            end
            default: begin
                w_opA = i_y;
                w_opB = i_y;
            end
        endcase
    end

    FloatingAddition u_add (
        .i_a      (w_opA),
        .i_b      (w_opB),
        .o_result (o_sum)
    );

endmodule

// File: rtl/sigmoid_inverse.sv
// Recovers the pre-activation x = s/(1-|s|), s = 2y-1, from a fast-sigmoid
// activation y using one shared adder and one divider over six states.
module sigmoid_inverse
    import sigmoid_inverse_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] num,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
);

    stateT       r_state;
    specialT     r_special;
    logic        r_loaded;
    logic        r_inReady;
    logic        r_outValid;
    logic [31:0] r_y, r_t, r_s, r_d, r_result;
    logic [31:0] w_addSum;
    logic [31:0] w_quotient;

    assign in_ready  = r_inReady;
    assign out_valid = r_outValid;
    assign result    = r_result;

    sigmoid_inverse_addstep u_addStep (
        .i_state (r_state),
        .i_y     (r_y),
        .i_t     (r_t),
        .i_sMag  (r_s[30:0]),
        .o_sum   (w_addSum)
    );

    FloatingDivision u_div (
        .i_a      (r_s),
        .i_b      (r_d),
        .o_result (w_quotient)
    );

    // The accepted activation spends one cycle registered in IDLE before the
    // datapath starts, so every operation takes exactly five cycles to OUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_special  <= SPEC_NONE;
            r_loaded   <= 1'b0;
            r_inReady  <= 1'b1;
            r_outValid <= 1'b0;
            r_y        <= 32'd0;
            r_t        <= 32'd0;
            r_s        <= 32'd0;
            r_d        <= 32'd0;
            r_result   <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_loaded) begin
                        r_loaded <= 1'b0;
                        r_state  <= DBL;
                    end else if (in_valid && r_inReady) begin
                        r_y       <= num;
                        r_special <= classifyInput(num);
                        r_inReady <= 1'b0;
                        r_loaded  <= 1'b1;
                    end
                end
                DBL: begin
                    r_t     <= w_addSum;
                    r_state <= SUB;
                end
                SUB: begin
                    r_s     <= w_addSum;
                    r_state <= DEN;
                end
                DEN: begin
                    r_d     <= w_addSum;
                    r_state <= DIV;
                end
                DIV: begin
                    case (r_special)
                        SPEC_NAN:     r_result <= FP_QNAN;
                        SPEC_POS_INF: r_result <= FP_POS_INF;
                        SPEC_NEG_INF: r_result <= FP_NEG_INF;
                        default:      r_result <= w_quotient;
                    endcase
                    r_outValid <= 1'b1;
                    r_state    <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        r_outValid <= 1'b0;
                        r_inReady  <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sigmoid_inverse.sv
// Self-checking bench for sigmoid_inverse: directed cases, backpressure,
// mid-operation reset and random activations against a real-arithmetic model.
module tb_sigmoid_inverse;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] num;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    int compareCount = 0;
    int failCount    = 0;

    sigmoid_inverse dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .num       (num),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Single-precision bits to real value (finite inputs only).
    function automatic real f2r(input logic [31:0] f);
        real v;
        if (f[30:23] == 8'd0)
            v = real'(f[22:0]) * $bitstoreal({1'b0, 11'd874, 52'd0});
        else
            v = $bitstoreal({1'b0, 11'(f[30:23]) + 11'd896, f[22:0], 29'd0});
        return f[31] ? -v : v;
    endfunction

    // Real value to single-precision bits, round-to-nearest-even.
    function automatic logic [31:0] r2f(input real r);
        logic [63:0] b, full, q, rem, half, enc;
        int          e, fexp, sh;
        logic        up;
        b = $realtobits(r);
        e = int'(b[62:52]);
        if (e == 2047)
            return (b[51:0] != 52'd0) ? 32'h7FC0_0000 : {b[63], 31'h7F80_0000};
        if (e == 0)
            return {b[63], 31'd0};
        fexp = e - 896;
        full = {11'd0, 1'b1, b[51:0]};
        sh   = (fexp >= 1) ? 29 : 30 - fexp;
        if (sh > 63) sh = 63;
        q    = full >> sh;
        rem  = full & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        up   = (rem > half) || ((rem == half) && q[0]);
        enc  = ((fexp >= 1) ? (64'(fexp - 1) << 23) : 64'd0) + q + 64'(up);
        if (enc >= 64'h7F80_0000)
            return {b[63], 31'h7F80_0000};
        return {b[63], enc[30:0]};
    endfunction

    // Each arithmetic step rounded to single precision, in the same order as
    // the hardware evaluates it: t = 2y, s = t - 1, d = 1 - |s|, x = s / d.
    function automatic logic [31:0] modelInverse(input logic [31:0] y);
        real         yr, sr;
        logic [31:0] t, s, d;
        if ((&y[30:23]) && (y[22:0] != 23'd0)) return 32'h7FC0_0000;
        if (&y[30:23]) return y[31] ? 32'hFF80_0000 : 32'h7F80_0000;
        yr = f2r(y);
        if (yr >= 1.0) return 32'h7F80_0000;
        if (yr <= 0.0) return 32'hFF80_0000;
        t  = r2f(2.0 * yr);
        s  = r2f(f2r(t) - 1.0);
        sr = f2r(s);
        d  = r2f(1.0 - ((sr < 0.0) ? -sr : sr));
        return r2f(sr / f2r(d));
    endfunction

    task automatic applyStimulus(input string tag, input logic [31:0] y,
                                 input logic [31:0] expected);
        int waitCycles;
        waitCycles = 0;
        while (!in_ready && waitCycles < 20) begin
            step();
            waitCycles++;
        end
        out_ready = 1'b1;
        num       = y;
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
        num       = $urandom;
        waitCycles = 0;
        while (!out_valid && waitCycles < 20) begin
            step();
            waitCycles++;
        end
        checkOutput({tag, " latency"}, 32'(waitCycles), 32'd5);
        checkOutput({tag, " result"}, result, expected);
        step();
        checkOutput({tag, " ready after"}, 32'(in_ready), 32'd1);
        checkOutput({tag, " valid after"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] y, x, yBack;
        real         xr;
        int          lat, ulpDiff;

        rst = 1'b1; in_valid = 1'b0; num = 32'd0; out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset result", result, 32'd0);

        applyStimulus("y=0.5", 32'h3F00_0000, 32'h0000_0000);
        applyStimulus("y=0.75", 32'h3F40_0000, 32'h3F80_0000);
        applyStimulus("y=0.25", 32'h3E80_0000, 32'hBF80_0000);
        applyStimulus("y=0.875", 32'h3F60_0000, 32'h4040_0000);
        applyStimulus("y=1.0", 32'h3F80_0000, 32'h7F80_0000);
        applyStimulus("y=+inf", 32'h7F80_0000, 32'h7F80_0000);
        applyStimulus("y=-0.5", 32'hBF00_0000, 32'hFF80_0000);
        applyStimulus("y=+0", 32'h0000_0000, 32'hFF80_0000);
        applyStimulus("y=-0", 32'h8000_0000, 32'hFF80_0000);
        applyStimulus("y=nan", 32'h7FC0_0001, 32'h7FC0_0000);
        applyStimulus("y=denorm", 32'h0000_0001, 32'hFF80_0000);

        // Backpressure with noise on the input side.
        out_ready = 1'b0;
        num       = 32'h3F60_0000;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        checkOutput("bp latency", 32'(lat), 32'd5);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom);
            num      = $urandom;
            step();
            checkOutput("bp result", result, 32'h4040_0000);
            checkOutput("bp out_valid", 32'(out_valid), 32'd1);
            checkOutput("bp in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checkOutput("bp release in_ready", 32'(in_ready), 32'd1);
        checkOutput("bp release out_valid", 32'(out_valid), 32'd0);
        applyStimulus("after bp", 32'h3F40_0000, 32'h3F80_0000);

        // Reset while in DEN: accept edge, then DBL, SUB, DEN.
        out_ready = 1'b1;
        num       = 32'h3F40_0000;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("abort out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort in_ready", 32'(in_ready), 32'd1);
        checkOutput("abort result", result, 32'd0);
        for (int i = 0; i < 8; i++) begin
            step();
            checkOutput("abort no result", 32'(out_valid), 32'd0);
        end

        $display("[TB] random activations");
        for (int i = 0; i < 40; i++) begin
            y = {1'b0, 8'($urandom_range(126, 107)), 23'($urandom)};
            x = modelInverse(y);
            applyStimulus("random", y, x);
            if (y[30:23] >= 8'd125) begin
                xr      = f2r(result);
                yBack   = r2f((xr / (1.0 + ((xr < 0.0) ? -xr : xr)) + 1.0) / 2.0);
                ulpDiff = (yBack > y) ? int'(yBack - y) : int'(y - yBack);
                checkOutput("random sigmoid ulp", 32'((ulpDiff > 2) ? ulpDiff : 0), 32'd0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
